mistral_mac_pipe: RTL and testbench

//   Pipelined signed multiply-accumulate model for the Mistral (Cyclone V) DSP block.

---
 rtl/mistral_dsp_pkg.sv | 35 +++
 rtl/mistral_mac_acc.sv | 68 ++++++
 rtl/mistral_mac_pipe.sv | 111 +++++++++++
 tb/tb_mistral_mac_pipe.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mistral_dsp_pkg.sv
// mistral_dsp_pkg: shared limits, stage count and saturation
// helper for the Mistral DSP multiply-accumulate models.
package mistral_dsp_pkg;

   localparam int MISTRAL_MUL_MAX_WIDTH = 27;
   localparam int MISTRAL_MAC_STAGES    = 3;
   localparam int MISTRAL_SAT_MAX       = 128;

   typedef struct packed {
      logic                       ovf;
      logic [MISTRAL_SAT_MAX-1:0] val;
   } sat_res_t;

   // Clamp a wide signed sum into a signed field of 'width' bits.
   function automatic sat_res_t sat_add(
      input logic signed [MISTRAL_SAT_MAX:0] sum,
      input int                              width
   );
      logic signed [MISTRAL_SAT_MAX:0] hi;
      logic signed [MISTRAL_SAT_MAX:0] lo;
      sat_res_t                        r;
      hi    = ((MISTRAL_SAT_MAX+1)'(1) <<< (width - 1))
            - (MISTRAL_SAT_MAX+1)'(1);
      lo    = -hi - (MISTRAL_SAT_MAX+1)'(1);
      r.ovf = (sum > hi) || (sum < lo);
      if (!r.ovf)
         r.val = sum[MISTRAL_SAT_MAX-1:0];
      else if (sum[MISTRAL_SAT_MAX])
         r.val = lo[MISTRAL_SAT_MAX-1:0];
      else
         r.val = hi[MISTRAL_SAT_MAX-1:0];
      return r;
   endfunction

endpackage

// File: rtl/mistral_mac_acc.sv
// mistral_mac_acc: stage-3 accumulator with load/subtract control.
// MISTRAL_MAC_SAT_EN selects saturating arithmetic and a sticky OVF.
module mistral_mac_acc #(
   parameter int ACC_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ena,
   input  logic                        v_in,
   input  logic                        load,
   input  logic                        sub,
   input  logic signed [ACC_WIDTH-1:0] p,
   output logic signed [ACC_WIDTH-1:0] y,
   output logic                        v_out,
   output logic                        ovf
);
   import mistral_dsp_pkg::*;

   logic signed [ACC_WIDTH-1:0] base;
   logic signed [ACC_WIDTH-1:0] nxt;

   assign base = load ? '0 : y;

`ifdef MISTRAL_MAC_SAT_EN
   localparam int SW = ACC_WIDTH + 1;

   logic signed [SW-1:0] base_x;
   logic signed [SW-1:0] add_x;
   logic signed [SW-1:0] sum_x;
   sat_res_t             sr;
   logic                 nxt_ovf;

   assign base_x  = SW'(base);
   assign add_x   = sub ? -SW'(p) : SW'(p);
   assign sum_x   = base_x + add_x;
   assign sr      = sat_add((MISTRAL_SAT_MAX+1)'(sum_x), ACC_WIDTH);
   assign nxt     = sr.val[ACC_WIDTH-1:0];
   assign nxt_ovf = sr.ovf;

   // Sticky overflow: set on clamp, cleared by a clean LOAD op.
   always_ff @(posedge clk) begin
      if (rst)
         ovf <= 1'b0;
      else if (ena && v_in) begin
         if (nxt_ovf)
            ovf <= 1'b1;
         else if (load)
            ovf <= 1'b0;
      end
   end
`else
   assign nxt = base + (sub ? -p : p);
   assign ovf = 1'b0;
`endif

   // Accumulator and output-valid register; bubbles leave y alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         y     <= '0;
         v_out <= 1'b0;
      end else if (ena) begin
         v_out <= v_in;
         if (v_in)
            y <= nxt;
      end
   end

endmodule

// File: rtl/mistral_mac_pipe.sv
// mistral_mac_pipe: 3-stage signed MAC model of the Mistral DSP block.
// Optional saturation: define MISTRAL_MAC_SAT_EN.
module mistral_mac_pipe #(
   parameter int A_SIGNED  = 0,
   parameter int B_SIGNED  = 1,
   parameter int A_WIDTH   = 18,
   parameter int B_WIDTH   = 18,
   parameter int ACC_WIDTH = 64
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        ENA,
   input  logic                        IN_VALID,
   input  logic        [A_WIDTH-1:0]   A,
   input  logic signed [B_WIDTH-1:0]   B,
   input  logic                        LOAD,
   input  logic                        SUB,
   output logic                        OUT_VALID,
   output logic signed [ACC_WIDTH-1:0] Y,
   output logic                        OVF
);
   import mistral_dsp_pkg::*;

   localparam int PW = A_WIDTH + B_WIDTH + 1;

   if (B_SIGNED != 1) begin : g_bad_bsig
      $error("B_SIGNED must be 1");
   end
   if (A_WIDTH < 1 || A_WIDTH > MISTRAL_MUL_MAX_WIDTH) begin : g_bad_aw
      $error("A_WIDTH out of range 1..27");
   end
   if (B_WIDTH < 1 || B_WIDTH > MISTRAL_MUL_MAX_WIDTH) begin : g_bad_bw
      $error("B_WIDTH out of range 1..27");
   end
   if (ACC_WIDTH < PW || ACC_WIDTH > MISTRAL_SAT_MAX) begin : g_bad_acc
      $error("ACC_WIDTH must cover A_WIDTH+B_WIDTH+1");
   end
   if (MISTRAL_MAC_STAGES != 3) begin : g_bad_stages
      $error("pipeline is built for three stages");
   end

   logic        [A_WIDTH-1:0]   a1;
   logic signed [B_WIDTH-1:0]   b1;
   logic                        load1;
   logic                        sub1;
   logic                        v1;
   logic signed [ACC_WIDTH-1:0] p2;
   logic                        load2;
   logic                        sub2;
   logic                        v2;

   logic signed [A_WIDTH:0]     a_ext;
   logic signed [PW-1:0]        a_x;
   logic signed [PW-1:0]        b_x;
   logic signed [PW-1:0]        prod;

   // A is widened by one bit so the unsigned case stays positive.
   assign a_ext = (A_SIGNED != 0) ? {a1[A_WIDTH-1], a1}
                                  : {1'b0, a1};
   assign a_x   = PW'(a_ext);
   assign b_x   = PW'(b1);
   assign prod  = a_x * b_x;

   // Stage 1: capture operands and controls.
   always_ff @(posedge CLK) begin
      if (RST) begin
         a1    <= '0;
         b1    <= '0;
         load1 <= 1'b0;
         sub1  <= 1'b0;
         v1    <= 1'b0;
      end else if (ENA) begin
         a1    <= A;
         b1    <= B;
         load1 <= LOAD;
         sub1  <= SUB;
         v1    <= IN_VALID;
      end
   end

   // Stage 2: register the sign-extended product.
   always_ff @(posedge CLK) begin
      if (RST) begin
         p2    <= '0;
         load2 <= 1'b0;
         sub2  <= 1'b0;
         v2    <= 1'b0;
      end else if (ENA) begin
         p2    <= ACC_WIDTH'(prod);
         load2 <= load1;
         sub2  <= sub1;
         v2    <= v1;
      end
   end

   mistral_mac_acc #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_acc (
      .clk   (CLK),
      .rst   (RST),
      .ena   (ENA),
      .v_in  (v2),
      .load  (load2),
      .sub   (sub2),
      .p     (p2),
      .y     (Y),
      .v_out (OUT_VALID),
      .ovf   (OVF)
   );

endmodule

// File: tb/tb_mistral_mac_pipe.sv
// tb_mistral_mac_pipe: directed vectors for the Mistral MAC pipe,
// signed and unsigned-A instances plus the saturating build.
module tb_mistral_mac_pipe;

   logic clk;
   logic rst;
   logic ena;
   logic in_valid;
   logic load;
   logic sub;

   logic        [17:0] a_s;
   logic signed [17:0] b_s;
   logic               ov_s;
   logic signed [63:0] y_s;
   logic               ovf_s;

   logic        [7:0]  a_u;
   logic signed [17:0] b_u;
   logic               ov_u;
   logic signed [63:0] y_u;
   logic               ovf_u;

   int n_chk;
   int n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mistral_mac_pipe #(
      .A_SIGNED  (1),
      .B_SIGNED  (1),
      .A_WIDTH   (18),
      .B_WIDTH   (18),
      .ACC_WIDTH (64)
   ) u_s (
      .CLK       (clk),
      .RST       (rst),
      .ENA       (ena),
      .IN_VALID  (in_valid),
      .A         (a_s),
      .B         (b_s),
      .LOAD      (load),
      .SUB       (sub),
      .OUT_VALID (ov_s),
      .Y         (y_s),
      .OVF       (ovf_s)
   );

   mistral_mac_pipe #(
      .A_SIGNED  (0),
      .B_SIGNED  (1),
      .A_WIDTH   (8),
      .B_WIDTH   (18),
      .ACC_WIDTH (64)
   ) u_u (
      .CLK       (clk),
      .RST       (rst),
      .ENA       (ena),
      .IN_VALID  (in_valid),
      .A         (a_u),
      .B         (b_u),
      .LOAD      (load),
      .SUB       (sub),
      .OUT_VALID (ov_u),
      .Y         (y_u),
      .OVF       (ovf_u)
   );

`ifdef MISTRAL_MAC_SAT_EN
   logic        [26:0] a_sat;
   logic signed [26:0] b_sat;
   logic               ov_sat;
   logic signed [54:0] y_sat;
   logic               ovf_sat;

   mistral_mac_pipe #(
      .A_SIGNED  (1),
      .B_SIGNED  (1),
      .A_WIDTH   (27),
      .B_WIDTH   (27),
      .ACC_WIDTH (55)
   ) u_sat (
      .CLK       (clk),
      .RST       (rst),
      .ENA       (ena),
      .IN_VALID  (in_valid),
      .A         (a_sat),
      .B         (b_sat),
      .LOAD      (load),
      .SUB       (sub),
      .OUT_VALID (ov_sat),
      .Y         (y_sat),
      .OVF       (ovf_sat)
   );
`endif

   task automatic check(
      input string              tag,
      input logic signed [63:0] got,
      input logic signed [63:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(
      input logic               v,
      input logic               l,
      input logic               s,
      input logic signed [17:0] a,
      input logic signed [17:0] b
   );
      in_valid = v;
      load     = l;
      sub      = s;
      a_s      = a;
      b_s      = b;
      a_u      = a[7:0];
      b_u      = b;
   endtask

`ifdef MISTRAL_MAC_SAT_EN
   logic signed [63:0] ey  [6];
   logic               eo  [6];
   logic signed [26:0] big;
`endif

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      ena   = 1'b1;
      put(0, 0, 0, 0, 0);
`ifdef MISTRAL_MAC_SAT_EN
      a_sat = '0;
      b_sat = '0;
`endif
      tick();
      tick();
      check("rst_y", y_s, 0);
      check("rst_ov", ov_s, 0);
      check("rst_ovf", ovf_s, 0);
      rst = 1'b0;

      // single op: -3 * 5 with load
      put(1, 1, 0, -3, 5);
      tick();
      check("t1_ov_e1", ov_s, 0);
      put(0, 0, 0, 0, 0);
      tick();
      check("t1_ov_e2", ov_s, 0);
      tick();
      check("t1_ov_e3", ov_s, 1);
      check("t1_y", y_s, -15);
      tick();
      check("t1_ov_e4", ov_s, 0);
      check("t1_y_hold", y_s, -15);

      // back-to-back stream: load, add, subtract
      put(1, 1, 0, 2, 3);
      tick();
      put(1, 0, 0, 4, 5);
      tick();
      put(1, 0, 1, 1, 7);
      tick();
      check("t2_ov0", ov_s, 1);
      check("t2_y0", y_s, 6);
      put(0, 0, 0, 0, 0);
      tick();
      check("t2_ov1", ov_s, 1);
      check("t2_y1", y_s, 26);
      tick();
      check("t2_ov2", ov_s, 1);
      check("t2_y2", y_s, 19);
      tick();
      check("t2_ov3", ov_s, 0);
      check("t2_y3", y_s, 19);

      // all-ones A: signed gives 1, zero-extended 8-bit gives -255
      put(1, 1, 0, -1, -1);
      tick();
      put(0, 0, 0, 0, 0);
      tick();
      tick();
      check("t3_ov_s", ov_s, 1);
      check("t3_y_s", y_s, 1);
      check("t3_ov_u", ov_u, 1);
      check("t3_y_u", y_u, -255);
      tick();

      // clock-enable stall of two cycles mid-stream
      put(1, 1, 0, 1, 1);
      tick();
      put(1, 0, 0, 2, 2);
      tick();
      put(1, 0, 0, 3, 3);
      tick();
      check("t4_y0", y_s, 1);
      put(0, 0, 0, 0, 0);
      ena = 1'b0;
      tick();
      check("t4_ov_st1", ov_s, 1);
      check("t4_y_st1", y_s, 1);
      tick();
      check("t4_ov_st2", ov_s, 1);
      check("t4_y_st2", y_s, 1);
      ena = 1'b1;
      tick();
      check("t4_ov1", ov_s, 1);
      check("t4_y1", y_s, 5);
      tick();
      check("t4_ov2", ov_s, 1);
      check("t4_y2", y_s, 14);
      tick();
      check("t4_ov3", ov_s, 0);

      // reset with two operations in flight
      put(1, 1, 0, 1, 10);
      tick();
      put(1, 0, 0, 1, 20);
      tick();
      rst = 1'b1;
      put(0, 0, 0, 0, 0);
      tick();
      check("t5_y", y_s, 0);
      check("t5_ov", ov_s, 0);
      check("t5_ovf", ovf_s, 0);
      check("t5_y_u", y_u, 0);
      rst = 1'b0;
      tick();
      check("t5_ov_a", ov_s, 0);
      tick();
      check("t5_ov_b", ov_s, 0);
      check("t5_y_b", y_s, 0);

`ifdef MISTRAL_MAC_SAT_EN
      // saturating accumulation of 2^52 until clamp, then clean load
      big   = 27'sh4000000;
      ey[0] = 64'sd1 <<< 52;
      ey[1] = 64'sd1 <<< 53;
      ey[2] = 64'sd3 <<< 52;
      ey[3] = (64'sd1 <<< 54) - 64'sd1;
      ey[4] = (64'sd1 <<< 54) - 64'sd1;
      ey[5] = 64'sd1;
      eo[0] = 1'b0;
      eo[1] = 1'b0;
      eo[2] = 1'b0;
      eo[3] = 1'b1;
      eo[4] = 1'b1;
      eo[5] = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c < 5) begin
            put(1, (c == 0), 0, 0, 0);
            a_sat = big;
            b_sat = big;
         end else if (c == 5) begin
            put(1, 1, 0, 0, 0);
            a_sat = 27'd1;
            b_sat = 27'sd1;
         end else begin
            put(0, 0, 0, 0, 0);
         end
         tick();
         if (c >= 2) begin
            check($sformatf("sat_y%0d", c - 2), y_sat, ey[c-2]);
            check($sformatf("sat_ovf%0d", c - 2), ovf_sat, eo[c-2]);
         end
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
